// File: rtl/bpi_flash_access_fsm.sv
// Control FSM for an asynchronous BPI parallel-flash bus. Each EXECUTE runs one single-word access:
// capture strobe, operation decode, address latch, then a timed write or read pulse, then recovery.
// Ports:
//   CLK      system clock, rising edge
//   RST      synchronous active-low reset
//   EXECUTE  start request, level-sampled in idle
//   READ     latched OP[1], sampled in decode only
//   WRITE    latched OP[0], sampled in decode only
//   BUSY     operation in progress
//   CAP      one-cycle strobe to capture address/data/OP externally
//   E        chip enable (active-high)
//   L        address latch enable (active-high)
//   W        write enable (active-high)
//   G        output enable (active-high)
//   LOAD     one-cycle strobe: read data on the bus is valid
module bpi_flash_access_fsm #(
   parameter int unsigned L_CYCLES   = 2,
   parameter int unsigned W_CYCLES   = 4,
   parameter int unsigned G_CYCLES   = 6,
   parameter int unsigned REC_CYCLES = 2,
   parameter int unsigned TMR        = 0
) (
   input  logic CLK,
   input  logic RST,
   input  logic EXECUTE,
   input  logic READ,
   input  logic WRITE,
   output logic BUSY,
   output logic CAP,
   output logic E,
   output logic L,
   output logic W,
   output logic G,
   output logic LOAD
);

   // Separate latch states per direction keep the whole operation in the (voted) state register.
   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StCapture = 3'd1,
      StDecode  = 3'd2,
      StLatchWr = 3'd3,
      StLatchRd = 3'd4,
      StWrPulse = 3'd5,
      StRdPulse = 3'd6,
      StRecover = 3'd7
   } state_e;

   localparam logic [3:0] LLast = 4'(L_CYCLES - 1);
   localparam logic [3:0] WLast = 4'(W_CYCLES - 1);
   localparam logic [3:0] GLast = 4'(G_CYCLES - 1);
   localparam logic [3:0] RLast = 4'(REC_CYCLES - 1);

   // Output vector bit order: {BUSY, CAP, E, L, W, G, LOAD}
   localparam logic [6:0] OBusy = 7'b100_0000;
   localparam logic [6:0] OCap  = 7'b010_0000;
   localparam logic [6:0] OE    = 7'b001_0000;
   localparam logic [6:0] OL    = 7'b000_1000;
   localparam logic [6:0] OW    = 7'b000_0100;
   localparam logic [6:0] OG    = 7'b000_0010;
   localparam logic [6:0] OLoad = 7'b000_0001;

   state_e     state_v;   // current state (voted when TMR is enabled)
   logic [3:0] cnt_v;     // current count (voted when TMR is enabled)
   state_e     state_d;
   logic [3:0] cnt_d;
   logic [6:0] out_d;
   logic [6:0] out_q;

   // Next state and counter: counter restarts at 0 on every state entry.
   always_comb begin
      state_d = state_v;
      cnt_d   = cnt_v + 4'd1;
      unique case (state_v)
         StIdle: begin
            cnt_d = '0;
            if (EXECUTE) state_d = StCapture;
         end
         StCapture: begin
            cnt_d   = '0;
            state_d = StDecode;
         end
         StDecode: begin
            cnt_d = '0;
            if (WRITE && !READ)      state_d = StLatchWr;
            else if (READ && !WRITE) state_d = StLatchRd;
            else                     state_d = StRecover;
         end
         StLatchWr: begin
            if (cnt_v == LLast) begin
               state_d = StWrPulse;
               cnt_d   = '0;
            end
         end
         StLatchRd: begin
            if (cnt_v == LLast) begin
               state_d = StRdPulse;
               cnt_d   = '0;
            end
         end
         StWrPulse: begin
            if (cnt_v == WLast) begin
               state_d = StRecover;
               cnt_d   = '0;
            end
         end
         StRdPulse: begin
            if (cnt_v == GLast) begin
               state_d = StRecover;
               cnt_d   = '0;
            end
         end
         StRecover: begin
            if (cnt_v == RLast) begin
               state_d = StIdle;
               cnt_d   = '0;
            end
         end
      endcase
   end

   // Outputs are decoded from the next state so the registered strobes always equal
   // decode(current state, current count) with no combinational path to the pads.
   always_comb begin
      out_d = '0;
      unique case (state_d)
         StIdle:    out_d = '0;
         StCapture: out_d = OBusy | OCap;
         StDecode:  out_d = OBusy;
         StLatchWr: out_d = OBusy | OE | OL;
         StLatchRd: out_d = OBusy | OE | OL;
         StWrPulse: out_d = OBusy | OE | OW;
         StRdPulse: out_d = OBusy | OE | OG | ((cnt_d == GLast) ? OLoad : 7'b0);
         StRecover: out_d = OBusy;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST) out_q <= '0;
      else      out_q <= out_d;
   end

   assign {BUSY, CAP, E, L, W, G, LOAD} = out_q;

   if (TMR != 0) begin : g_tmr
      logic [2:0] state0_q, state1_q, state2_q;
      logic [3:0] cnt0_q, cnt1_q, cnt2_q;

      // All copies reload from the voted next value, so a single upset clears in one clock.
      always_ff @(posedge CLK) begin
         if (!RST) begin
            state0_q <= StIdle;
            state1_q <= StIdle;
            state2_q <= StIdle;
            cnt0_q   <= '0;
            cnt1_q   <= '0;
            cnt2_q   <= '0;
         end else begin
            state0_q <= state_d;
            state1_q <= state_d;
            state2_q <= state_d;
            cnt0_q   <= cnt_d;
            cnt1_q   <= cnt_d;
            cnt2_q   <= cnt_d;
         end
      end

      assign state_v = state_e'((state0_q & state1_q) | (state0_q & state2_q) |
                                (state1_q & state2_q));
      assign cnt_v   = (cnt0_q & cnt1_q) | (cnt0_q & cnt2_q) | (cnt1_q & cnt2_q);
   end else begin : g_single
      state_e     state_q;
      logic [3:0] cnt_q;

      always_ff @(posedge CLK) begin
         if (!RST) begin
            state_q <= StIdle;
            cnt_q   <= '0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
         end
      end

      assign state_v = state_q;
      assign cnt_v   = cnt_q;
   end

endmodule

// File: tb/tb_bpi_flash_access_fsm.sv
// Directed bench for bpi_flash_access_fsm: a plain instance and a TMR instance share stimulus and
// are both compared, cycle by cycle, against an expected strobe schedule built from the timing
// parameters.
module tb_bpi_flash_access_fsm;

   localparam int unsigned LC = 2;
   localparam int unsigned WC = 4;
   localparam int unsigned GC = 6;
   localparam int unsigned RC = 2;

   // Op kinds
   localparam int KWrite = 0;
   localparam int KRead  = 1;
   localparam int KOp00  = 2;
   localparam int KOp11  = 3;

   logic clk;
   logic rst_n;
   logic execute;
   logic rd;
   logic wr;

   logic busy_a, cap_a, e_a, l_a, w_a, g_a, load_a;
   logic busy_t, cap_t, e_t, l_t, w_t, g_t, load_t;

   int n_cmp;
   int n_bad;

   bpi_flash_access_fsm #(
      .L_CYCLES(LC), .W_CYCLES(WC), .G_CYCLES(GC), .REC_CYCLES(RC), .TMR(0)
   ) dut (
      .CLK(clk), .RST(rst_n), .EXECUTE(execute), .READ(rd), .WRITE(wr),
      .BUSY(busy_a), .CAP(cap_a), .E(e_a), .L(l_a), .W(w_a), .G(g_a), .LOAD(load_a)
   );

   bpi_flash_access_fsm #(
      .L_CYCLES(LC), .W_CYCLES(WC), .G_CYCLES(GC), .REC_CYCLES(RC), .TMR(1)
   ) dut_t (
      .CLK(clk), .RST(rst_n), .EXECUTE(execute), .READ(rd), .WRITE(wr),
      .BUSY(busy_t), .CAP(cap_t), .E(e_t), .L(l_t), .W(w_t), .G(g_t), .LOAD(load_t)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Bit order {BUSY, CAP, E, L, W, G, LOAD}
   function automatic logic [6:0] exp_vec(input int kind, input int i);
      int lat_end, pulse_end, total;
      lat_end = 2 + int'(LC);
      if (kind == KWrite)     pulse_end = lat_end + int'(WC);
      else if (kind == KRead) pulse_end = lat_end + int'(GC);
      else                    pulse_end = 2;
      total = pulse_end + int'(RC);
      if (i == 0) return 7'b110_0000;
      if (i == 1) return 7'b100_0000;
      if (kind == KWrite || kind == KRead) begin
         if (i < lat_end) return 7'b101_1000;
         if (i < pulse_end) begin
            if (kind == KWrite) return 7'b101_0100;
            return (i == pulse_end - 1) ? 7'b101_0011 : 7'b101_0010;
         end
      end
      if (i < total) return 7'b100_0000;
      return 7'b000_0000;
   endfunction

   function automatic int op_len(input int kind);
      if (kind == KWrite) return 2 + int'(LC + WC + RC);
      if (kind == KRead)  return 2 + int'(LC + GC + RC);
      return 2 + int'(RC);
   endfunction

   task automatic check_both(input string tag, input logic [6:0] exp);
      check_eq({tag, "/plain"}, {25'd0, busy_a, cap_a, e_a, l_a, w_a, g_a, load_a}, {25'd0, exp});
      check_eq({tag, "/tmr"}, {25'd0, busy_t, cap_t, e_t, l_t, w_t, g_t, load_t}, {25'd0, exp});
   endtask

   // Runs n_ops back-to-back operations (EXECUTE held until the last one starts), checking every
   // cycle through the idle cycle that follows the last one.
   task automatic run_op(input string name, input int kind, input int n_ops, input bit flip_op,
                         input bit corrupt);
      int per;
      per = op_len(kind) + 1;
      rd  = (kind == KRead || kind == KOp11);
      wr  = (kind == KWrite || kind == KOp11);
      execute = 1'b1;
      for (int i = 0; i < n_ops * per; i++) begin
         @(posedge clk);
         #1;
         check_both($sformatf("%s[%0d]", name, i), exp_vec(kind, i % per));
         if (i == (n_ops - 1) * per) execute = 1'b0;
         // Decode has already happened; swapping the op must not matter.
         if (flip_op && i == 2) begin
            rd = ~rd;
            wr = ~wr;
         end
         if (corrupt) begin
            if (i == 4) force dut_t.g_tmr.state1_q = 3'd0;
            if (i == 6) release dut_t.g_tmr.state1_q;
            if (i == 7) force dut_t.g_tmr.cnt2_q = 4'hf;
            if (i == 8) release dut_t.g_tmr.cnt2_q;
         end
      end
   endtask

   initial begin
      n_cmp   = 0;
      n_bad   = 0;
      rst_n   = 1'b0;
      execute = 1'b1;
      rd      = 1'b0;
      wr      = 1'b1;

      // Reset held with EXECUTE high: everything stays quiet.
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check_both($sformatf("reset[%0d]", i), 7'b0);
      end
      rst_n   = 1'b1;
      execute = 1'b0;
      @(posedge clk);
      #1;
      check_both("reset_release", 7'b0);

      run_op("write", KWrite, 1, 1'b0, 1'b0);
      run_op("read", KRead, 1, 1'b0, 1'b0);
      run_op("op00", KOp00, 1, 1'b0, 1'b0);
      run_op("op11", KOp11, 1, 1'b0, 1'b0);
      run_op("write_held", KWrite, 2, 1'b0, 1'b0);
      run_op("write_flip", KWrite, 1, 1'b1, 1'b0);
      run_op("read_flip", KRead, 1, 1'b1, 1'b0);
      run_op("write_seu", KWrite, 1, 1'b0, 1'b1);
      run_op("read_seu", KRead, 1, 1'b0, 1'b1);

      // Reset in the middle of the read pulse: strobes drop on that edge, no LOAD follows.
      rd      = 1'b1;
      wr      = 1'b0;
      execute = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         check_both($sformatf("rd_abort[%0d]", i), exp_vec(KRead, i));
         if (i == 0) execute = 1'b0;
      end
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check_both($sformatf("rd_abort_rst[%0d]", i), 7'b0);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         check_both($sformatf("rd_abort_idle[%0d]", i), 7'b0);
      end

      // A fresh operation after the abort runs normally.
      run_op("read_after_abort", KRead, 1, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
